// File: rtl/hp1349a_bus_rx.sv
// hp1349a_bus_rx
// Receive front end for the HP 1349A parallel display bus. Synchronizes and
// glitch-filters the host LDAV strobe, runs the LDAV/LRFD four-phase
// handshake and queues each 15-bit bus word in a show-ahead FIFO.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus_ldav_n   host data-available strobe (async, active low)
//   bus_data     host data word (async, stable around the strobe)
//   bus_lrfd_n   ready-for-data back to the host (active low)
//   word_data    FIFO head word
//   word_valid   FIFO not empty
//   word_ready   consumer pop request (pops when word_valid & word_ready)
//   fifo_level   current word count, 0..2^DEPTH_LOG2
//   glitch_cnt   saturating count of rejected LDAV pulses
module hp1349a_bus_rx #(
  parameter int FILT       = 4,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bus_ldav_n,
  input  logic [14:0]           bus_data,
  output logic                  bus_lrfd_n,
  output logic [14:0]           word_data,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic [7:0]            glitch_cnt
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [7:0]          FILT_LAST = 8'(FILT - 1);
  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  logic                  ldav_meta_r;
  logic                  ldav_sync_r;
  logic [14:0]           data_meta_r;
  logic [14:0]           data_sync_r;
  logic                  ldav_filt_r;
  logic [7:0]            fcnt_r;
  logic [7:0]            glitch_cnt_r;
  state_t                state_r;
  state_t                state_nxt_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  full_s;
  logic                  lrfd_n_s;
  logic [14:0]           mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;

  // Two-flop synchronizer for strobe and data. Deliberately not reset: it
  // keeps sampling through reset so that, at release, the FSM already sees
  // whether the host is still holding LDAV low from an interrupted transfer.
  always_ff @(posedge clk) begin
    ldav_meta_r <= bus_ldav_n;
    ldav_sync_r <= ldav_meta_r;
    data_meta_r <= bus_data;
    data_sync_r <= data_meta_r;
  end

  // Level filter: the filtered strobe follows the synchronized one only after
  // FILT consecutive cycles of disagreement; aborted runs count as glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldav_filt_r  <= 1'b1;
      fcnt_r       <= 8'd0;
      glitch_cnt_r <= 8'd0;
    end else if (ldav_sync_r == ldav_filt_r) begin
      fcnt_r <= 8'd0;
      if ((fcnt_r != 8'd0) && (glitch_cnt_r != 8'hFF)) begin
        glitch_cnt_r <= glitch_cnt_r + 8'd1;
      end
    end else if (fcnt_r == FILT_LAST) begin
      ldav_filt_r <= ldav_sync_r;
      fcnt_r      <= 8'd0;
    end else begin
      fcnt_r <= fcnt_r + 8'd1;
    end
  end

  // Handshake state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HOLD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic. Leaving HOLD also requires the raw synchronized level to
  // be high, so a host still holding LDAV low across reset stays stalled.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HOLD: begin
        if (ldav_filt_r && ldav_sync_r && !full_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      ST_IDLE: begin
        if (!ldav_filt_r) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_HOLD;
    endcase
  end

  // Output decode: LRFD asserted only in IDLE; the capture happens on the
  // edge that leaves IDLE.
  always_comb begin
    lrfd_n_s = 1'b1;
    wr_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        lrfd_n_s = 1'b0;
        wr_en_s  = ~ldav_filt_r;
      end
      ST_HOLD: begin
        lrfd_n_s = 1'b1;
        wr_en_s  = 1'b0;
      end
      default: begin
        lrfd_n_s = 1'b1;
        wr_en_s  = 1'b0;
      end
    endcase
  end

  assign full_s  = (level_r == LVL_FULL);
  assign rd_en_s = word_ready && (level_r != '0);

  // FIFO storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 15'd0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= data_sync_r;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Word count; a simultaneous write and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= '0;
    end else begin
      case ({wr_en_s, rd_en_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign bus_lrfd_n = lrfd_n_s;
  assign word_data  = mem_r[rd_ptr_r];
  assign word_valid = (level_r != '0);
  assign fifo_level = level_r;
  assign glitch_cnt = glitch_cnt_r;

endmodule

// File: tb/tb_hp1349a_bus_rx.sv
// Directed self-checking bench for hp1349a_bus_rx (FILT=4, DEPTH_LOG2=3).
module tb_hp1349a_bus_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_ldav_n = 1'b1;
  logic [14:0] bus_data = 15'd0;
  logic        bus_lrfd_n;
  logic [14:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic [3:0]  fifo_level;
  logic [7:0]  glitch_cnt;

  int chk_cnt = 0;
  int pass_cnt = 0;

  hp1349a_bus_rx #(.FILT(4), .DEPTH_LOG2(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus_ldav_n (bus_ldav_n),
    .bus_data   (bus_data),
    .bus_lrfd_n (bus_lrfd_n),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .fifo_level (fifo_level),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop LDAV with a word and count edges until LRFD rises (bounded at 20).
  task automatic ldav_fall(input logic [14:0] d, output int n);
    bus_data   = d;
    bus_ldav_n = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus_lrfd_n !== 1'b1 && n < 20);
  endtask

  // Raise LDAV and count edges until LRFD falls (bounded at 20).
  task automatic ldav_rise(output int n);
    bus_ldav_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus_lrfd_n !== 1'b0 && n < 20);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_ldav_n = 1'b1;
    repeat (4) tick();
    chk_cnt++; if (bus_lrfd_n !== 1'b1) $display("FAIL reset_lrfd got %b want 1", bus_lrfd_n); else pass_cnt++;
    chk_cnt++; if (word_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", word_valid); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else pass_cnt++;
    chk_cnt++; if (glitch_cnt !== 8'd0) $display("FAIL reset_glitch got %0d want 0", glitch_cnt); else pass_cnt++;
    chk_cnt++; if (word_data !== 15'd0) $display("FAIL reset_data got %h want 0", word_data); else pass_cnt++;
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (bus_lrfd_n !== 1'b1) $display("FAIL release_lrfd_before_edge got %b want 1", bus_lrfd_n); else pass_cnt++;
    tick();
    chk_cnt++; if (bus_lrfd_n !== 1'b0) $display("FAIL release_lrfd_first_edge got %b want 0", bus_lrfd_n); else pass_cnt++;
    chk_cnt++; if (word_valid !== 1'b0 || fifo_level !== 4'd0) $display("FAIL release_fifo got valid=%b level=%0d want 0/0", word_valid, fifo_level); else pass_cnt++;
  endtask

  task automatic test_single_word();
    int n;
    ldav_fall(15'h2A5A, n);
    chk_cnt++; if (n < 7 || n > 8) $display("FAIL single_fall_latency got %0d want 7..8", n); else pass_cnt++;
    repeat (20 - n) tick();
    chk_cnt++; if (word_data !== 15'h2A5A) $display("FAIL single_data got %h want 2a5a", word_data); else pass_cnt++;
    chk_cnt++; if (word_valid !== 1'b1) $display("FAIL single_valid got %b want 1", word_valid); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd1) $display("FAIL single_level got %0d want 1", fifo_level); else pass_cnt++;
    ldav_rise(n);
    chk_cnt++; if (n < 7 || n > 8) $display("FAIL single_rise_latency got %0d want 7..8", n); else pass_cnt++;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk_cnt++; if (fifo_level !== 4'd0 || word_valid !== 1'b0) $display("FAIL single_pop got level=%0d valid=%b want 0/0", fifo_level, word_valid); else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic lrfd_rose = 1'b0;
    for (int g = 0; g < 300; g++) begin
      bus_ldav_n = 1'b0;
      tick();
      if (bus_lrfd_n !== 1'b0) lrfd_rose = 1'b1;
      tick();
      if (bus_lrfd_n !== 1'b0) lrfd_rose = 1'b1;
      bus_ldav_n = 1'b1;
      repeat (4) begin
        tick();
        if (bus_lrfd_n !== 1'b0) lrfd_rose = 1'b1;
      end
      if (g == 0) begin
        chk_cnt++; if (glitch_cnt !== 8'd1) $display("FAIL glitch_first got %0d want 1", glitch_cnt); else pass_cnt++;
        chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL glitch_first_level got %0d want 0", fifo_level); else pass_cnt++;
      end
    end
    chk_cnt++; if (glitch_cnt !== 8'd255) $display("FAIL glitch_saturate got %0d want 255", glitch_cnt); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL glitch_no_write got %0d want 0", fifo_level); else pass_cnt++;
    chk_cnt++; if (lrfd_rose !== 1'b0) $display("FAIL glitch_lrfd_steady got %b want 0", lrfd_rose); else pass_cnt++;
  endtask

  task automatic test_fill();
    int n;
    logic hs_bad = 1'b0;
    logic stall_bad = 1'b0;
    logic order_bad = 1'b0;
    for (int w = 1; w <= 8; w++) begin
      ldav_fall(15'(w), n);
      if (n >= 20) hs_bad = 1'b1;
      repeat (3) tick();
      if (w < 8) begin
        ldav_rise(n);
        if (n >= 20) hs_bad = 1'b1;
      end
    end
    chk_cnt++; if (hs_bad !== 1'b0) $display("FAIL fill_handshakes got timeout=%b want 0", hs_bad); else pass_cnt++;
    bus_ldav_n = 1'b1;
    repeat (15) begin
      tick();
      if (bus_lrfd_n !== 1'b1) stall_bad = 1'b1;
    end
    chk_cnt++; if (stall_bad !== 1'b0) $display("FAIL fill_stall got lrfd_fell=%b want 0", stall_bad); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd8) $display("FAIL fill_level got %0d want 8", fifo_level); else pass_cnt++;
    chk_cnt++; if (word_data !== 15'd1) $display("FAIL fill_head got %h want 0001", word_data); else pass_cnt++;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk_cnt++; if (bus_lrfd_n !== 1'b1) $display("FAIL pop_edge_lrfd got %b want 1", bus_lrfd_n); else pass_cnt++;
    tick();
    chk_cnt++; if (bus_lrfd_n !== 1'b0) $display("FAIL pop_next_edge_lrfd got %b want 0", bus_lrfd_n); else pass_cnt++;
    ldav_fall(15'd9, n);
    chk_cnt++; if (n < 7 || n > 8) $display("FAIL word9_latency got %0d want 7..8", n); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd8) $display("FAIL word9_level got %0d want 8", fifo_level); else pass_cnt++;
    repeat (3) tick();
    bus_ldav_n = 1'b1;
    repeat (8) tick();
    word_ready = 1'b1;
    for (int e = 2; e <= 9; e++) begin
      if (word_data !== 15'(e)) begin
        order_bad = 1'b1;
        $display("FAIL fill_pop_word got %h want %h", word_data, 15'(e));
      end
      tick();
    end
    word_ready = 1'b0;
    chk_cnt++; if (order_bad !== 1'b0) $display("FAIL fill_order got bad=%b want 0", order_bad); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd0) $display("FAIL fill_drained got %0d want 0", fifo_level); else pass_cnt++;
    tick();
    chk_cnt++; if (bus_lrfd_n !== 1'b0) $display("FAIL fill_resume got %b want 0", bus_lrfd_n); else pass_cnt++;
  endtask

  task automatic test_simul_write_pop();
    int n;
    logic order_bad = 1'b0;
    for (int w = 0; w < 3; w++) begin
      ldav_fall(15'h100 + 15'(w), n);
      repeat (2) tick();
      ldav_rise(n);
    end
    chk_cnt++; if (fifo_level !== 4'd3) $display("FAIL simul_prefill got %0d want 3", fifo_level); else pass_cnt++;
    bus_data   = 15'h103;
    bus_ldav_n = 1'b0;
    repeat (6) tick();
    chk_cnt++; if (bus_lrfd_n !== 1'b0 || word_data !== 15'h100) $display("FAIL simul_pre got lrfd=%b head=%h want 0/0100", bus_lrfd_n, word_data); else pass_cnt++;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk_cnt++; if (bus_lrfd_n !== 1'b1) $display("FAIL simul_write_edge got lrfd=%b want 1", bus_lrfd_n); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd3) $display("FAIL simul_level got %0d want 3", fifo_level); else pass_cnt++;
    word_ready = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      if (word_data !== 15'h100 + 15'(e)) order_bad = 1'b1;
      tick();
    end
    word_ready = 1'b0;
    chk_cnt++; if (order_bad !== 1'b0 || fifo_level !== 4'd0) $display("FAIL simul_order got bad=%b level=%0d want 0/0", order_bad, fifo_level); else pass_cnt++;
    ldav_rise(n);
  endtask

  task automatic test_reset_mid();
    int n;
    logic stall_bad = 1'b0;
    ldav_fall(15'h0555, n);
    repeat (2) tick();
    ldav_rise(n);
    chk_cnt++; if (fifo_level !== 4'd1) $display("FAIL mid_prefill got %0d want 1", fifo_level); else pass_cnt++;
    bus_data   = 15'h0777;
    bus_ldav_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    chk_cnt++; if (fifo_level !== 4'd0 || word_valid !== 1'b0) $display("FAIL mid_flush got level=%0d valid=%b want 0/0", fifo_level, word_valid); else pass_cnt++;
    chk_cnt++; if (bus_lrfd_n !== 1'b1) $display("FAIL mid_lrfd got %b want 1", bus_lrfd_n); else pass_cnt++;
    repeat (15) begin
      tick();
      if (bus_lrfd_n !== 1'b1 || fifo_level !== 4'd0) stall_bad = 1'b1;
    end
    chk_cnt++; if (stall_bad !== 1'b0) $display("FAIL mid_stalled got bad=%b want 0", stall_bad); else pass_cnt++;
    ldav_rise(n);
    chk_cnt++; if (n < 7 || n > 8) $display("FAIL mid_release_latency got %0d want 7..8", n); else pass_cnt++;
    chk_cnt++; if (fifo_level !== 4'd0 || word_data !== 15'd0) $display("FAIL mid_no_word got level=%0d data=%h want 0/0000", fifo_level, word_data); else pass_cnt++;
    ldav_fall(15'h0123, n);
    repeat (2) tick();
    chk_cnt++; if (word_data !== 15'h0123 || fifo_level !== 4'd1) $display("FAIL mid_after got data=%h level=%0d want 0123/1", word_data, fifo_level); else pass_cnt++;
    ldav_rise(n);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_glitch();
    test_fill();
    test_simul_write_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
